// File: rtl/reg_debug_pkg.sv
// Shared definitions for the register-file debug port: default widths,
// command opcode encoding and controller state enum.
package reg_debug_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;

  localparam logic OP_DUMP = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_debug_port.sv
// Debug initiator for the CPU register file: halts the CPU and dumps a register
// range onto a valid/ready stream, or loads a range from an incoming stream.
module reg_debug_port
  import reg_debug_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_adr,
  input  logic [ADDR_W:0]   i_cmd_count,
  output logic [ADDR_W-1:0] o_rf_read_adr,
  input  logic [DATA_W-1:0] i_rf_read_data,
  output logic              o_rf_write_en,
  output logic [ADDR_W-1:0] o_rf_write_adr,
  output logic [DATA_W-1:0] o_rf_write_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_adr,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_cpu_halt,
  output logic              o_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cur_adr;
  logic [ADDR_W-1:0] w_cur_adr_nxt;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  w_remaining_nxt;
  logic              w_last;

  // State register and transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur_adr   <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_adr   <= w_cur_adr_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  assign w_last = (r_remaining == CNT_W'(1));

  // Next-state, counter update and stream/register-file handshake decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_adr_nxt   = r_cur_adr;
    w_remaining_nxt = r_remaining;
    o_cmd_ready     = 1'b0;
    o_out_valid     = 1'b0;
    o_out_adr       = '0;
    o_out_data      = '0;
    o_in_ready      = 1'b0;
    o_rf_write_en   = 1'b0;
    o_rf_write_adr  = '0;
    o_rf_write_data = '0;
    o_done          = 1'b0;

    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_cur_adr_nxt   = i_cmd_adr;
          w_remaining_nxt = i_cmd_count;
          if (i_cmd_count == '0)       w_state_nxt = DONE;
          else if (i_cmd_op == OP_LOAD) w_state_nxt = LOAD;
          else                          w_state_nxt = DUMP;
        end
      end
      DUMP: begin
        o_out_valid = 1'b1;
        o_out_adr   = r_cur_adr;
        o_out_data  = i_rf_read_data;
        if (i_out_ready) begin
          w_cur_adr_nxt   = r_cur_adr + ADDR_W'(1);
          w_remaining_nxt = r_remaining - CNT_W'(1);
          if (w_last) w_state_nxt = DONE;
        end
      end
      LOAD: begin
        o_in_ready      = 1'b1;
        o_rf_write_en   = i_in_valid;
        o_rf_write_adr  = r_cur_adr;
        o_rf_write_data = i_in_data;
        if (i_in_valid) begin
          w_cur_adr_nxt   = r_cur_adr + ADDR_W'(1);
          w_remaining_nxt = r_remaining - CNT_W'(1);
          if (w_last) w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_rf_read_adr = r_cur_adr;
  assign o_cpu_halt    = (r_state != IDLE);

endmodule

// File: tb/tb_reg_debug_port.sv
// Self-checking bench for reg_debug_port: directed scenarios plus random
// commands, checked cycle by cycle against a behavioural register-file model.
module tb_reg_debug_port;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [3:0] cmd_adr;
  logic [4:0] cmd_count;
  logic [3:0] rf_read_adr;
  logic [7:0] rf_read_data;
  logic       rf_write_en;
  logic [3:0] rf_write_adr;
  logic [7:0] rf_write_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_adr;
  logic [7:0] out_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       cpu_halt;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rf_mem  [16];
  logic [7:0] ref_mem [16];
  logic [7:0] load_q  [$];
  logic       rdy_q   [$];

  reg_debug_port dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_op       (cmd_op),
    .i_cmd_adr      (cmd_adr),
    .i_cmd_count    (cmd_count),
    .o_rf_read_adr  (rf_read_adr),
    .i_rf_read_data (rf_read_data),
    .o_rf_write_en  (rf_write_en),
    .o_rf_write_adr (rf_write_adr),
    .o_rf_write_data(rf_write_data),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_adr      (out_adr),
    .o_out_data     (out_data),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .o_cpu_halt     (cpu_halt),
    .o_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file beside the DUT: r0 always reads as zero.
  always_ff @(posedge clk) begin
    if (rf_write_en) rf_mem[rf_write_adr] <= rf_write_data;
  end
  assign rf_read_data = (rf_read_adr == 4'd0) ? 8'h00 : rf_mem[rf_read_adr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [3:0] a);
    return (a == 4'd0) ? 8'h00 : ref_mem[a];
  endfunction

  task automatic run_load(input logic [3:0] adr, input logic [4:0] cnt, input bit rnd,
                          input int abort_after, output int halt_cyc);
    int         idx;
    int         guard;
    logic [3:0] a;
    halt_cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_adr = adr; cmd_count = cnt;
    #1;
    check("ld_accept_ready", 32'(cmd_ready), 32'd1);
    check("ld_accept_halt", 32'(cpu_halt), 32'd0);
    idx = 0;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 1'($urandom);
    cmd_adr = 4'($urandom); cmd_count = 5'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    while (idx < int'(cnt) && guard < 100) begin
      if (idx == abort_after) begin
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        return;
      end
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (load_q.size() > 0) ? load_q[0] : 8'($urandom);
      #1;
      if (cpu_halt) halt_cyc++;
      check("ld_in_ready", 32'(in_ready), 32'd1);
      check("ld_busy_cmd_ready", 32'(cmd_ready), 32'd0);
      check("ld_halt", 32'(cpu_halt), 32'd1);
      check("ld_no_out_valid", 32'(out_valid), 32'd0);
      check("ld_write_en", 32'(rf_write_en), 32'(in_valid));
      if (in_valid) begin
        a = 4'(int'(adr) + idx);
        check("ld_write_adr", 32'(rf_write_adr), 32'(a));
        check("ld_write_data", 32'(rf_write_data), 32'(in_data));
        ref_mem[a] = in_data;
        if (load_q.size() > 0) void'(load_q.pop_front());
        idx++;
      end
      guard++;
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1)); cmd_adr = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    check("ld_beat_count", 32'(idx), 32'(cnt));
    cmd_valid = 1'b0;
    in_valid  = 1'($urandom_range(0, 1));
    #1;
    if (cpu_halt) halt_cyc++;
    check("ld_done_pulse", 32'(done), 32'd1);
    check("ld_done_no_write", 32'(rf_write_en), 32'd0);
    check("ld_done_in_ready", 32'(in_ready), 32'd0);
    check("ld_done_halt", 32'(cpu_halt), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ld_after_done", 32'(done), 32'd0);
    check("ld_after_halt", 32'(cpu_halt), 32'd0);
    check("ld_after_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_dump(input logic [3:0] adr, input logic [4:0] cnt, input bit rnd,
                          input bit hold);
    int         idx;
    int         guard;
    logic [3:0] a;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_adr = adr; cmd_count = cnt;
    #1;
    check("dp_accept_ready", 32'(cmd_ready), 32'd1);
    idx = 0;
    guard = 0;
    @(negedge clk);
    if (hold) begin
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_adr = 4'd7; cmd_count = 5'd0;
    end else begin
      cmd_valid = 1'b0; cmd_adr = 4'($urandom); cmd_count = 5'($urandom);
    end
    while (idx < int'(cnt) && guard < 100) begin
      if (rdy_q.size() > 0) out_ready = rdy_q.pop_front();
      else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      #1;
      a = 4'(int'(adr) + idx);
      check("dp_out_valid", 32'(out_valid), 32'd1);
      check("dp_out_adr", 32'(out_adr), 32'(a));
      check("dp_out_data", 32'(out_data), 32'(exp_read(a)));
      check("dp_read_adr", 32'(rf_read_adr), 32'(a));
      check("dp_busy_cmd_ready", 32'(cmd_ready), 32'd0);
      check("dp_halt", 32'(cpu_halt), 32'd1);
      check("dp_no_write", 32'(rf_write_en), 32'd0);
      check("dp_no_in_ready", 32'(in_ready), 32'd0);
      if (out_ready) idx++;
      guard++;
      @(negedge clk);
    end
    check("dp_beat_count", 32'(idx), 32'(cnt));
    if (!hold) cmd_valid = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    in_valid  = 1'b0;
    #1;
    check("dp_done_pulse", 32'(done), 32'd1);
    check("dp_done_out_valid", 32'(out_valid), 32'd0);
    check("dp_done_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("dp_after_done", 32'(done), 32'd0);
    check("dp_after_halt", 32'(cpu_halt), 32'd0);
    check("dp_after_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int         hc;
    logic       op;
    logic [3:0] adr;
    logic [4:0] cnt;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_adr = '0; cmd_count = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_halt", 32'(cpu_halt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_write_en", 32'(rf_write_en), 32'd0);
    check("rst_read_adr", 32'(rf_read_adr), 32'd0);

    // Fill every register so later dumps have defined contents.
    run_load(4'd0, 5'd16, 1'b1, -1, hc);

    // Back-to-back LOAD of three registers.
    load_q = '{8'h11, 8'h22, 8'h33};
    run_load(4'd3, 5'd3, 1'b0, -1, hc);
    check("ld3_halt_cycles", 32'(hc), 32'd4);
    check("ld3_rf_r3", 32'(rf_mem[3]), 32'h11);
    check("ld3_rf_r5", 32'(rf_mem[5]), 32'h33);

    // DUMP with stalls on the sink side.
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_dump(4'd3, 5'd3, 1'b0, 1'b0);

    // Address wrap through r0.
    load_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load(4'd14, 5'd4, 1'b0, -1, hc);
    run_dump(4'd14, 5'd4, 1'b0, 1'b0);

    // Zero-length commands.
    run_load(4'd5, 5'd0, 1'b0, -1, hc);
    run_dump(4'd9, 5'd0, 1'b0, 1'b0);

    // Command held during a DUMP is taken only once the port is idle again.
    run_dump(4'd2, 5'd3, 1'b1, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("held_cmd_done", 32'(done), 32'd1);
    check("held_cmd_halt", 32'(cpu_halt), 32'd1);
    @(negedge clk);
    #1;
    check("held_cmd_idle", 32'(cmd_ready), 32'd1);

    // Reset in the middle of a LOAD.
    run_load(4'd8, 5'd5, 1'b0, 2, hc);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_write_en", 32'(rf_write_en), 32'd0);
    check("midrst_halt", 32'(cpu_halt), 32'd0);
    check("midrst_read_adr", 32'(rf_read_adr), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    in_valid = 1'b0;

    // Random commands, including counts beyond the register count.
    repeat (24) begin
      op  = 1'($urandom_range(0, 1));
      adr = 4'($urandom);
      cnt = 5'($urandom_range(0, 20));
      if (op) run_load(adr, cnt, 1'b1, -1, hc);
      else    run_dump(adr, cnt, 1'b1, 1'b0);
    end
    run_dump(4'd0, 5'd16, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
